seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexes NUM_DIGITS hex digits onto one shared seven-segment bus. Each digit is driven in turn for a fixed dwell time, with an all-off blanking gap between digits to prevent ghosting.
New display values enter through a load strobe and become visible only at a frame boundary, so a frame never shows a torn value.
Sits between the switch/register datapath and the board's common-anode display pins. It replaces direct switch-to-segment decoding once more than one digit is driven.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DWELL_CYCLES, 50000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 1000, clk cycles all digits are off between digits (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value_in  input  4*NUM_DIGITS  hex value to display; nibble k drives digit k; digit 0 is rightmost and least significant
load  input  1  one-cycle strobe that captures value_in into the pending register
seven_seg  output  7  active-low segments; bit0=a … bit6=g
digit_en  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time
frame_start  output  1  one-cycle pulse when the frame for digit 0 begins
update_pending  output  1  high while a loaded value awaits commit

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset values:
  - seven_seg = 7'h7F
  - digit_en = all ones
  - frame_start = 0
  - update_pending = 0
  - active and pending registers = 0
  - state = BLANK, digit index = 0, cycle counter = 0
- State machine, two states:
  - BLANK: digit_en all ones, seven_seg = 7'h7F. Lasts exactly BLANK_CYCLES cycles, then goes to DWELL.
  - DWELL: digit_en[idx] = 0, seven_seg = decode(active nibble idx). Lasts exactly DWELL_CYCLES cycles, then goes to BLANK.
  - On DWELL->BLANK, idx increments and wraps from NUM_DIGITS-1 to 0.
  - Frame period = NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES).
- Cycle counter is sized to max(DWELL_CYCLES, BLANK_CYCLES). It resets to 0 on every state change.
- frame_start is high during the first cycle of each BLANK with idx = 0, including the first BLANK after reset.
- Commit: on the frame_start cycle, if update_pending = 1, active <= pending and update_pending <= 0. Commit happens at that edge, so digit 0's dwell in the same frame shows the new value.
- Load: load = 1 sets pending <= value_in and update_pending <= 1. Back-to-back loads overwrite; the last one before the frame boundary wins.
- Simultaneous load and commit (load high on the frame_start cycle):
  - active <= value_in (bypass)
  - update_pending <= 0
  - pending <= value_in
- Decode, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-DWELL: outputs return to reset values on the next edge and the scan restarts from BLANK with idx 0. Any pending update is discarded.
- After reset, the display shows 0 on every digit until the first commit.

Optional Feature:
Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
- Defined: during DWELL, any digit k > 0 whose nibble and all higher nibbles of active are zero is blanked.
  - Blanked means digit_en stays all ones and seven_seg = 7'h7F for that dwell.
  - Timing is unchanged.
  - Digit 0 is always shown.
- Undefined: every digit is displayed, including leading zeros.

Test Plan:
All tests use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
1. Reset, then run 30 cycles.
   -> digit_en stays 1111 for 2 cycles, then 1110 for 4 cycles, then 1111 for 2, then 1101, and so on.
   -> seven_seg = 1000000 during each dwell.
   -> frame_start pulses at cycle 0 and cycle 24.
2. Load value_in=16'h12AF mid-frame.
   -> update_pending = 1 until the next frame_start.
   -> The next frame shows F, A, 2, 1 on digits 0..3 as 0001110, 0001000, 0100100, 1111001.
3. Load 16'h1111 and then 16'h2222 within one frame.
   -> Only 2222 is displayed; 1111 never appears.
4. Assert load with 16'h0008 on the frame_start cycle.
   -> Digit 0 shows 0000000 in that same frame.
   -> update_pending stays 0.
5. Assert reset during digit 2's dwell, with pending set.
   -> Next cycle: seven_seg = 7F, digit_en = 1111, update_pending = 0.
   -> The following frame displays 0000.
6. With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, commit 16'h0050.
   -> Digits 0 and 1 light, showing 0 and 5.
   -> digit_en stays 1111 during the dwells for digits 2 and 3.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// Bus bundle between the display datapath (master) and the seven-segment scan controller (slave).
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [6:0]              seven_seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_start;
  logic                    update_pending;

  modport master (
    output value_in, load,
    input  seven_seg, digit_en, frame_start, update_pending
  );

  modport slave (
    input  value_in, load,
    output seven_seg, digit_en, frame_start, update_pending
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with blanking gaps and frame-aligned value commit.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  seven_seg_scan_if.slave  bus
);
  localparam int VW      = 4 * NUM_DIGITS;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {BLANK, DWELL} state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [VW-1:0]         active, active_d, pending, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fs_q, fs_d, upd_q, upd_d;
  logic [3:0]            nib;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_above;
`endif

  function automatic logic [6:0] decode_hex(input logic [3:0] h);
    case (h)
      4'h0: decode_hex = 7'h40;
      4'h1: decode_hex = 7'h79;
      4'h2: decode_hex = 7'h24;
      4'h3: decode_hex = 7'h30;
      4'h4: decode_hex = 7'h19;
      4'h5: decode_hex = 7'h12;
      4'h6: decode_hex = 7'h02;
      4'h7: decode_hex = 7'h78;
      4'h8: decode_hex = 7'h00;
      4'h9: decode_hex = 7'h10;
      4'hA: decode_hex = 7'h08;
      4'hB: decode_hex = 7'h03;
      4'hC: decode_hex = 7'h46;
      4'hD: decode_hex = 7'h21;
      4'hE: decode_hex = 7'h06;
      default: decode_hex = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BLANK;
      idx     <= '0;
      cnt     <= '0;
      active  <= '0;
      pending <= '0;
      seg_q   <= 7'h7F;
      en_q    <= '1;
      fs_q    <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      active  <= active_d;
      pending <= pending_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      upd_q   <= upd_d;
    end
  end

  // Outputs are registered from the current scan state, so the pins trail the
  // internal state by one cycle; the commit is keyed off the registered pulse.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt + CNT_W'(1);
    active_d  = active;
    pending_d = pending;
    upd_d     = upd_q;
    seg_d     = 7'h7F;
    en_d      = '1;
    nib       = '0;

    case (state)
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = DWELL;
          cnt_d   = '0;
        end
      end
      DWELL: begin
        if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
      end
    endcase

    if (bus.load) begin
      pending_d = bus.value_in;
      upd_d     = 1'b1;
    end
    // A load coinciding with the frame boundary bypasses straight into active.
    if (fs_q) begin
      if (bus.load)
        active_d = bus.value_in;
      else if (upd_q)
        active_d = pending;
      upd_d = 1'b0;
    end

    fs_d = (state == BLANK) && (cnt == '0) && (idx == '0);

    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx == IDX_W'(k))
        nib = active_d[k*4 +: 4];

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    lz         = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (active_d[k*4 +: 4] == 4'h0);
      lz[k]      = zero_above;
    end
`endif

    if (state == DWELL) begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (!lz[idx]) begin
        seg_d = decode_hex(nib);
        for (int k = 0; k < NUM_DIGITS; k++)
          if (idx == IDX_W'(k))
            en_d[k] = 1'b0;
      end
`else
      seg_d = decode_hex(nib);
      for (int k = 0; k < NUM_DIGITS; k++)
        if (idx == IDX_W'(k))
          en_d[k] = 1'b0;
`endif
    end
  end

  assign bus.seven_seg      = seg_q;
  assign bus.digit_en       = en_q;
  assign bus.frame_start    = fs_q;
  assign bus.update_pending = upd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: per-cycle scoreboard against a frame-position model,
// a table of load vectors, and hand-written bypass and mid-dwell reset sequences.
module tb_seven_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = ND * SLOT;

  logic clk = 1'b0;
  logic reset;

  seven_seg_scan_if #(.NUM_DIGITS(ND)) bus();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
    logic       fs;
    logic       upd;
  } exp_t;

  typedef struct {
    logic [15:0]     val1;
    int              pos1;
    logic [15:0]     val2;
    int              pos2;
    logic [3:0][6:0] segs;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[4];
  logic [6:0]  seg_tab[16];
  int          checks = 0;
  int          errors = 0;
  int          m_pos;
  logic [15:0] m_active, m_pending;
  logic        m_upd;

  // Expected pins from the position within the frame (pos -1 = first cycle after a reset edge).
  function automatic exp_t model_out();
    exp_t e;
    int   d, w;
    logic [15:0] upper;
    e.upd = m_upd;
    e.fs  = 1'b0;
    e.seg = 7'h7F;
    e.en  = 4'hF;
    if (m_pos >= 0) begin
      e.fs  = (m_pos == 0);
      d     = m_pos / SLOT;
      w     = m_pos % SLOT;
      upper = m_active >> (4 * d);
      if (w >= BL) begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (d == 0 || upper != 16'h0) begin
          e.seg = seg_tab[upper[3:0]];
          e.en  = ~(4'b0001 << d);
        end
`else
        e.seg = seg_tab[upper[3:0]];
        e.en  = ~(4'b0001 << d);
`endif
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] val);
    exp_t e;
    reset        = rst;
    bus.load     = ld;
    bus.value_in = val;
    if (rst) begin
      m_pos     = -1;
      m_active  = '0;
      m_pending = '0;
      m_upd     = 1'b0;
    end else begin
      if (m_pos == 0) begin
        if (ld)
          m_active = val;
        else if (m_upd)
          m_active = m_pending;
      end
      if (ld)
        m_pending = val;
      m_upd = (m_pos == 0) ? 1'b0 : (ld ? 1'b1 : m_upd);
      m_pos = (m_pos + 1) % FRAME;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = exp_q.pop_front();
      checkOutput("cycle", 32'({bus.seven_seg, bus.digit_en, bus.frame_start, bus.update_pending}),
                  32'(e));
    end
  endtask

  initial begin
    logic        ld;
    logic [15:0] val;
    logic [6:0]  want;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'h12AF, 8, 16'h0000, -1, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[1] = '{16'h1111, 3, 16'h2222, 15, {7'h24, 7'h24, 7'h24, 7'h24}};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vecs[2] = '{16'h0050, 10, 16'h0000, -1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
`else
    vecs[2] = '{16'h0050, 10, 16'h0000, -1, {7'h40, 7'h40, 7'h12, 7'h40}};
`endif
    vecs[3] = '{16'h3C9E, 20, 16'h0000, -1, {7'h30, 7'h46, 7'h10, 7'h06}};

    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = '0;
    m_pos        = -1;
    m_active     = '0;
    m_pending    = '0;
    m_upd        = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("reset_seg", 32'(bus.seven_seg), 32'h7F);
    checkOutput("reset_en", 32'(bus.digit_en), 32'hF);
    checkOutput("reset_fs", 32'(bus.frame_start), 32'h0);

    // Free-running scan of the all-zero power-up value.
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 16'h0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < FRAME && m_pos != 1; i++) applyStimulus(1'b0, 1'b0, 16'h0);
      for (int i = 0; i < FRAME - 1; i++) begin
        ld  = (m_pos == vecs[v].pos1) || (m_pos == vecs[v].pos2);
        val = (m_pos == vecs[v].pos2) ? vecs[v].val2 : vecs[v].val1;
        applyStimulus(1'b0, ld, val);
      end
      checkOutput($sformatf("vec%0d_pending", v), 32'(bus.update_pending), 32'h1);
      for (int i = 0; i < FRAME; i++) begin
        applyStimulus(1'b0, 1'b0, 16'h0);
        if (m_pos % SLOT == BL)
          checkOutput($sformatf("vec%0d_dig%0d", v, m_pos / SLOT), 32'(bus.seven_seg),
                      32'(vecs[v].segs[m_pos / SLOT]));
      end
    end

    // Load on the frame_start cycle goes straight to the display.
    for (int i = 0; i < FRAME && m_pos != 0; i++) applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("bypass_fs", 32'(bus.frame_start), 32'h1);
    applyStimulus(1'b0, 1'b1, 16'h0008);
    checkOutput("bypass_pending", 32'(bus.update_pending), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("bypass_dig0", 32'(bus.seven_seg), 32'h00);

    // Reset during digit 2's dwell discards the pending value.
    for (int i = 0; i < FRAME && m_pos != 1; i++) applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'hABCD);
    for (int i = 0; i < FRAME && m_pos != 2 * SLOT + BL; i++) applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("rst_pre_pending", 32'(bus.update_pending), 32'h1);
    checkOutput("rst_pre_en", 32'(bus.digit_en), 32'hB);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("rst_seg", 32'(bus.seven_seg), 32'h7F);
    checkOutput("rst_en", 32'(bus.digit_en), 32'hF);
    checkOutput("rst_pending", 32'(bus.update_pending), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("rst_fs", 32'(bus.frame_start), 32'h1);
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (m_pos % SLOT == BL) begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        want = (m_pos / SLOT == 0) ? 7'h40 : 7'h7F;
`else
        want = 7'h40;
`endif
        checkOutput($sformatf("rst_dig%0d", m_pos / SLOT), 32'(bus.seven_seg), 32'(want));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
